// File: rtl/cfg_reg_bank_if.sv
// Config register bus: write and read request/response channels of the
// eth_ctrl AXI-lite decoder side. The decoder drives the master side, the
// register bank sits on the slave side.
interface cfg_reg_bank_if #(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32
);
  logic                        cfg_wr_en;
  logic [REG_ADDR_WIDTH-1:0]   cfg_wr_addr;
  logic [REG_DATA_WIDTH-1:0]   cfg_wr_data;
  logic [REG_DATA_WIDTH/8-1:0] cfg_wr_strb;
  logic                        cfg_wr_ack;
  logic                        cfg_wr_err;
  logic                        cfg_rd_en;
  logic [REG_ADDR_WIDTH-1:0]   cfg_rd_addr;
  logic                        cfg_rd_vld;
  logic [REG_DATA_WIDTH-1:0]   cfg_rd_data;
  logic                        cfg_rd_err;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_strb,
    output cfg_rd_en, cfg_rd_addr,
    input  cfg_wr_ack, cfg_wr_err, cfg_rd_vld, cfg_rd_data, cfg_rd_err
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_wr_strb,
    input  cfg_rd_en, cfg_rd_addr,
    output cfg_wr_ack, cfg_wr_err, cfg_rd_vld, cfg_rd_data, cfg_rd_err
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// Parametrised config/status register bank. Each word has per-bit
// RW / W1C / RO attributes, byte-strobe writes, hardware-set sticky status
// bits and a one-cycle write ack / read response with address error flag.

// One register word. Attribute masks are elaboration constants, so each bit
// collapses to a plain flop with a small next-state cone.
module cfg_reg_word #(
  parameter int           W    = 32,
  parameter logic [W-1:0] INIT = '0,
  parameter logic [W-1:0] RW   = '1,
  parameter logic [W-1:0] W1C  = '0
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  input  logic         wr_hit,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] bm,
  input  logic [W-1:0] hw_set,
  output logic [W-1:0] q
);
  // RW wins where both masks are set; bits with neither attribute are constants.
  localparam logic [W-1:0] W1C_EFF = W1C & ~RW;
  localparam logic [W-1:0] RO      = ~(RW | W1C);

  logic [W-1:0] clr;
  logic [W-1:0] rw_nxt;
  logic [W-1:0] nxt;

  // Next value: strobed RW update, W1C clear then hw set (set wins), RO pinned.
  always_comb begin
    clr    = wr_hit ? (wr_data & bm & W1C_EFF) : '0;
    rw_nxt = q;
    if (wr_hit) rw_nxt = (q & ~(RW & bm)) | (wr_data & RW & bm);
    nxt    = (rw_nxt & RW) | (((q & ~clr) | hw_set) & W1C_EFF) | (INIT & RO);
  end

  // Register state, reset to its initial value.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) q <= INIT;
    else                q <= nxt;
  end
endmodule

module cfg_reg_bank #(
  parameter int                                   REG_ADDR_WIDTH = 32,
  parameter int                                   REG_DATA_WIDTH = 32,
  parameter int                                   REG_NUM        = 4,
  parameter logic [REG_ADDR_WIDTH-1:0]            BASE_ADDR      = 'h400,
  parameter logic [REG_NUM*REG_DATA_WIDTH-1:0]    INIT_VALUES    = '0,
  parameter logic [REG_NUM*REG_DATA_WIDTH-1:0]    RW_MASK        = '1,
  parameter logic [REG_NUM*REG_DATA_WIDTH-1:0]    W1C_MASK       = '0
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  cfg_reg_bank_if.slave                     cfg,
  input  logic [REG_NUM*REG_DATA_WIDTH-1:0] hw_sts_set,
  output logic [REG_NUM*REG_DATA_WIDTH-1:0] cfg_regs,
  output logic [REG_NUM-1:0]                cfg_wr_pulse
);
  localparam int AW     = REG_ADDR_WIDTH;
  localparam int DW     = REG_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int STAGES = 1;

  // Offset is taken at full address width, so addresses below the base wrap
  // to a huge word index and fail the range check.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ((off >> 2) < AW'(REG_NUM));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [REG_NUM-1:0][DW-1:0] regs;
  logic [REG_NUM-1:0][DW-1:0] hw_arr;
  logic [REG_NUM-1:0]         wr_hit;
  logic [DW-1:0]              bm;
  logic                       wr_ok, rd_ok;
  logic [IDX_W-1:0]           wr_idx, rd_idx;

  logic [STAGES:0]            wr_vld_pipe;
  logic [STAGES:0]            rd_vld_pipe;
  logic                       wr_err_q, rd_err_q;
  logic [DW-1:0]              rd_data_q;

  assign hw_arr   = hw_sts_set;
  assign cfg_regs = regs;

  assign wr_ok  = addr_ok(cfg.cfg_wr_addr);
  assign wr_idx = addr_idx(cfg.cfg_wr_addr);
  assign rd_ok  = addr_ok(cfg.cfg_rd_addr);
  assign rd_idx = addr_idx(cfg.cfg_rd_addr);

  genvar b, r;
  generate
    for (b = 0; b < STRB_W; b++) begin : g_bm
      assign bm[b*8 +: 8] = {8{cfg.cfg_wr_strb[b]}};
    end

    for (r = 0; r < REG_NUM; r++) begin : g_reg
      assign wr_hit[r] = cfg.cfg_wr_en && wr_ok && (wr_idx == IDX_W'(r));

      cfg_reg_word #(
        .W    (DW),
        .INIT (INIT_VALUES[r*DW +: DW]),
        .RW   (RW_MASK[r*DW +: DW]),
        .W1C  (W1C_MASK[r*DW +: DW])
      ) u_word (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .wr_hit        (wr_hit[r]),
        .wr_data       (cfg.cfg_wr_data),
        .bm            (bm),
        .hw_set        (hw_arr[r]),
        .q             (regs[r])
      );
    end
  endgenerate

  assign wr_vld_pipe[0] = cfg.cfg_wr_en;
  assign rd_vld_pipe[0] = cfg.cfg_rd_en;

  // Write response: ack, error and per-register pulse one cycle after request.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_vld_pipe[STAGES:1] <= '0;
      wr_err_q              <= 1'b0;
      cfg_wr_pulse          <= '0;
    end else begin
      wr_vld_pipe[STAGES:1] <= wr_vld_pipe[STAGES-1:0];
      wr_err_q              <= cfg.cfg_wr_en && !wr_ok;
      cfg_wr_pulse          <= wr_hit;
    end
  end

  // Read response: data sampled pre-write in the request cycle, held between reads.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_vld_pipe[STAGES:1] <= '0;
      rd_err_q              <= 1'b0;
      rd_data_q             <= '0;
    end else begin
      rd_vld_pipe[STAGES:1] <= rd_vld_pipe[STAGES-1:0];
      rd_err_q              <= cfg.cfg_rd_en && !rd_ok;
      if (cfg.cfg_rd_en) rd_data_q <= rd_ok ? regs[rd_idx] : '0;
    end
  end

  assign cfg.cfg_wr_ack  = wr_vld_pipe[STAGES];
  assign cfg.cfg_wr_err  = wr_err_q;
  assign cfg.cfg_rd_vld  = rd_vld_pipe[STAGES];
  assign cfg.cfg_rd_err  = rd_err_q;
  assign cfg.cfg_rd_data = rd_data_q;
endmodule

// File: tb/tb_cfg_reg_bank.sv
// Scoreboard bench for cfg_reg_bank: the driver issues requests and pushes
// expected responses / register snapshots computed by a bit-level model; a
// monitor pops and compares whenever the DUT responds.
module tb_cfg_reg_bank;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam logic [31:0] BASE = 32'h400;
  // reg3: RW [31:28],[7:0]; W1C [27:24]; RO [23:8]
  // reg2: RW [31:16]; RO [15:8]; W1C [7:0]
  localparam logic [127:0] INIT = {32'h5AC3_960F, 32'h1234_5600, 32'h9000_0000, 32'h0000_0000};
  localparam logic [127:0] RWM  = {32'hF000_00FF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [127:0] W1CM = {32'hFF00_0000, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0000};

  logic s_axi_aclk = 1'b0;
  logic s_axi_aresetn = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  cfg_reg_bank_if #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) cfg_bus();
  logic [127:0] hw_sts_set;
  logic [127:0] cfg_regs;
  logic [N-1:0] cfg_wr_pulse;

  cfg_reg_bank #(
    .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .REG_NUM(N), .BASE_ADDR(BASE),
    .INIT_VALUES(INIT), .RW_MASK(RWM), .W1C_MASK(W1CM)
  ) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .cfg           (cfg_bus.slave),
    .hw_sts_set    (hw_sts_set),
    .cfg_regs      (cfg_regs),
    .cfg_wr_pulse  (cfg_wr_pulse)
  );

  typedef struct { int due; logic err; logic [31:0] val; } rsp_t;
  typedef struct { int due; logic [127:0] regs; } snap_t;
  rsp_t  wr_q[$];
  rsp_t  rd_q[$];
  snap_t snap_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] mdl [N];
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Address rule from plain integer arithmetic.
  function automatic bit dec(input logic [31:0] a, output int idx);
    longint ua;
    ua  = longint'({32'b0, a});
    idx = 0;
    if (a[1:0] != 2'b00 || ua < longint'({32'b0, BASE})) return 0;
    if ((ua - longint'({32'b0, BASE})) / 4 >= N) return 0;
    idx = int'((ua - longint'({32'b0, BASE})) / 4);
    return 1;
  endfunction

  function automatic logic [127:0] mdl_packed();
    logic [127:0] p;
    for (int r = 0; r < N; r++) p[r*32 +: 32] = mdl[r];
    return p;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) mdl[r] = INIT[r*32 +: 32];
    last_rd = '0;
  endtask

  // One request cycle: drive at negedge, predict responses and next state.
  task automatic step(input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit rd, input logic [31:0] ra,
                      input logic [127:0] hw);
    int wi, ri, bi;
    bit wv, rv, hit, en;
    rsp_t e;
    snap_t s;
    @(negedge s_axi_aclk);
    cfg_bus.cfg_wr_en   = wr;
    cfg_bus.cfg_wr_addr = wa;
    cfg_bus.cfg_wr_data = wd;
    cfg_bus.cfg_wr_strb = ws;
    cfg_bus.cfg_rd_en   = rd;
    cfg_bus.cfg_rd_addr = ra;
    hw_sts_set          = hw;
    wv = dec(wa, wi);
    rv = dec(ra, ri);
    if (rd) begin
      e.due = cyc + 1; e.err = !rv; e.val = rv ? mdl[ri] : 32'h0;
      rd_q.push_back(e);
    end
    if (wr) begin
      e.due = cyc + 1; e.err = !wv; e.val = wv ? (32'h1 << wi) : 32'h0;
      wr_q.push_back(e);
    end
    for (int r = 0; r < N; r++) begin
      hit = wr && wv && (wi == r);
      for (int k = 0; k < 32; k++) begin
        bi = r*32 + k;
        en = ws[k/8];
        if (RWM[bi]) begin
          if (hit && en) mdl[r][k] = wd[k];
        end else if (W1CM[bi]) begin
          mdl[r][k] = (mdl[r][k] && !(hit && en && wd[k])) || hw[bi];
        end else begin
          mdl[r][k] = INIT[bi];
        end
      end
    end
    s.due = cyc + 1; s.regs = mdl_packed();
    snap_q.push_back(s);
  endtask

  task automatic idle();
    step(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 128'h0);
  endtask

  // Monitor: compare DUT responses against the scoreboard queues.
  initial begin
    rsp_t  e;
    snap_t s;
    forever begin
      @(posedge s_axi_aclk);
      cyc++;
      #1;
      if (s_axi_aresetn) begin
        if (cfg_bus.cfg_wr_ack) begin
          if (wr_q.size() == 0) chk("wr_ack_unexpected", 128'(cfg_bus.cfg_wr_ack), 128'h0);
          else begin
            e = wr_q.pop_front();
            chk("wr_latency", 128'(cyc), 128'(e.due));
            chk("wr_err", 128'(cfg_bus.cfg_wr_err), 128'(e.err));
            chk("wr_pulse", 128'(cfg_wr_pulse), 128'(e.val));
          end
        end else begin
          chk("wr_pulse_idle", 128'(cfg_wr_pulse), 128'h0);
          if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
            e = wr_q.pop_front();
            chk("wr_ack_missing", 128'(cfg_bus.cfg_wr_ack), 128'h1);
          end
        end
        if (cfg_bus.cfg_rd_vld) begin
          if (rd_q.size() == 0) chk("rd_vld_unexpected", 128'(cfg_bus.cfg_rd_vld), 128'h0);
          else begin
            e = rd_q.pop_front();
            chk("rd_latency", 128'(cyc), 128'(e.due));
            chk("rd_err", 128'(cfg_bus.cfg_rd_err), 128'(e.err));
            chk("rd_data", 128'(cfg_bus.cfg_rd_data), 128'(e.val));
            last_rd = e.val;
          end
        end else begin
          chk("rd_err_idle", 128'(cfg_bus.cfg_rd_err), 128'h0);
          chk("rd_data_hold", 128'(cfg_bus.cfg_rd_data), 128'(last_rd));
          if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            chk("rd_vld_missing", 128'(cfg_bus.cfg_rd_vld), 128'h1);
          end
        end
        while (snap_q.size() != 0 && snap_q[0].due <= cyc) begin
          s = snap_q.pop_front();
          chk("cfg_regs", cfg_regs, s.regs);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_regs"},    cfg_regs, INIT);
    chk({tag, "_wr_ack"},  128'(cfg_bus.cfg_wr_ack), 128'h0);
    chk({tag, "_wr_err"},  128'(cfg_bus.cfg_wr_err), 128'h0);
    chk({tag, "_rd_vld"},  128'(cfg_bus.cfg_rd_vld), 128'h0);
    chk({tag, "_rd_err"},  128'(cfg_bus.cfg_rd_err), 128'h0);
    chk({tag, "_rd_data"}, 128'(cfg_bus.cfg_rd_data), 128'h0);
    chk({tag, "_pulse"},   128'(cfg_wr_pulse), 128'h0);
  endtask

  // Driver: directed scenarios, then random traffic.
  initial begin
    logic [31:0] addrs [10];
    logic [127:0] hw;
    addrs = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h402,
              32'h3FC, 32'hFFFF_FFFC, 32'h408, 32'h40C};
    cfg_bus.cfg_wr_en = 0; cfg_bus.cfg_wr_addr = '0; cfg_bus.cfg_wr_data = '0;
    cfg_bus.cfg_wr_strb = '0; cfg_bus.cfg_rd_en = 0; cfg_bus.cfg_rd_addr = '0;
    hw_sts_set = '0;
    model_reset();
    repeat (3) @(negedge s_axi_aclk);
    check_reset_state("reset");
    s_axi_aresetn = 1'b1;

    // same-cycle write and read of reg0: read returns the old value
    step(1, 32'h400, 32'h0000_1234, 4'hF, 1, 32'h400, 128'h0);
    idle();
    // strobed write to reg1, then read it back
    step(1, 32'h404, 32'hA5A5_A5A5, 4'b0011, 0, 32'h0, 128'h0);
    step(0, 32'h0, 32'h0, 4'h0, 1, 32'h404, 128'h0);
    // back-to-back reads, last one out of range
    step(0, 32'h0, 32'h0, 4'h0, 1, 32'h40C, 128'h0);
    step(0, 32'h0, 32'h0, 4'h0, 1, 32'h410, 128'h0);
    // misaligned and below-base writes
    step(1, 32'h402, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 128'h0);
    step(1, 32'h3FC, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 128'h0);
    // reg2 bit0 sticky: hw set, clear racing set, clear alone
    step(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 128'h1 << 64);
    step(1, 32'h408, 32'h1, 4'h1, 0, 32'h0, 128'h1 << 64);
    step(1, 32'h408, 32'h1, 4'h1, 1, 32'h408, 128'h0);
    // writes into RO and overlapping-mask bits of reg3
    step(1, 32'h40C, 32'hFFFF_FFFF, 4'hF, 1, 32'h40C, 128'h0);
    step(1, 32'h40C, 32'h0000_0000, 4'hF, 1, 32'h40C, 128'h0);
    idle();

    for (int i = 0; i < 600; i++) begin
      hw = ($urandom_range(0, 3) == 0) ?
           ({$urandom, $urandom, $urandom, $urandom} & {4{$urandom}}) : 128'h0;
      step($urandom_range(0, 1) == 1, addrs[$urandom_range(0, 9)], $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           addrs[$urandom_range(0, 9)], hw);
    end
    idle();

    // reset asserted during a read-request cycle aborts it
    @(negedge s_axi_aclk);
    cfg_bus.cfg_wr_en = 0;
    cfg_bus.cfg_rd_en = 1;
    cfg_bus.cfg_rd_addr = 32'h404;
    hw_sts_set = '0;
    #2;
    s_axi_aresetn = 1'b0;
    wr_q.delete(); rd_q.delete(); snap_q.delete();
    model_reset();
    @(negedge s_axi_aclk);
    cfg_bus.cfg_rd_en = 0;
    check_reset_state("midrst");
    s_axi_aresetn = 1'b1;
    repeat (4) idle();
    repeat (3) @(negedge s_axi_aclk);

    chk("wr_q_drained",   128'(wr_q.size()),   128'h0);
    chk("rd_q_drained",   128'(rd_q.size()),   128'h0);
    chk("snap_q_drained", 128'(snap_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
